// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised modulo up/down counter with prescaler, terminal count and sticky overflow
//
// Optional feature macro: COUNTER_SAT_EN (defined: saturate at the range ends
// instead of wrapping; tc and ovf behave the same in both builds).
//
// Parameters: WIDTH (count width), MODULUS (count range 0..MODULUS-1),
//             PRESCALE (enabled cycles per count step, >= 1)
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   en       - count enable, gates prescaler and stepping
//   up       - direction, 1 = up, 0 = down
//   load     - synchronous load strobe, wins over stepping, ignores en
//   load_val - value to load, clamped to MODULUS-1
//   clr_ovf  - clears the sticky overflow flag
//   out      - current count
//   tc       - one-cycle pulse in the cycle after a boundary step
//   ovf      - sticky overflow/underflow flag

module mod_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             ovf
);

   // Prescaler needs at least one bit even when PRESCALE = 1.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   // Top of range held in WIDTH bits so MODULUS = 2^WIDTH compares exactly.
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
   localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0]    presc;
   logic [PW-1:0]    presc_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic [WIDTH-1:0] load_clamped;
   logic             step;
   logic             boundary;

   always_comb begin
      load_clamped = (load_val > MAXV) ? MAXV : load_val;
      step         = en && !load && (presc == PMAX);
      boundary     = step && (up ? (out == MAXV) : (out == '0));

      presc_nxt = presc;
      if (load) begin
         presc_nxt = '0;
      end else if (en) begin
         presc_nxt = (presc == PMAX) ? '0 : presc + 1'b1;
      end

      out_nxt = out;
      if (load) begin
         out_nxt = load_clamped;
      end else if (boundary) begin
`ifdef COUNTER_SAT_EN
         out_nxt = up ? MAXV : '0;
`else
         out_nxt = up ? '0 : MAXV;
`endif
      end else if (step) begin
         out_nxt = up ? out + 1'b1 : out - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out   <= '0;
         presc <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         out   <= out_nxt;
         presc <= presc_nxt;
         tc    <= boundary;
         // A boundary step on the same edge as clr_ovf keeps the flag set.
         if (boundary) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - self-checking bench for mod_counter

module tb_mod_counter;

`ifdef COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       clr_ovf = 1'b0;

   logic [3:0] out10, out16, out3;
   logic       tc10, tc16, tc3;
   logic       ovf10, ovf16, ovf3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u10 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr_ovf(clr_ovf), .out(out10), .tc(tc10), .ovf(ovf10)
   );

   mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u16 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr_ovf(clr_ovf), .out(out16), .tc(tc16), .ovf(ovf16)
   );

   mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u3 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr_ovf(clr_ovf), .out(out3), .tc(tc3), .ovf(ovf3)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic       up;
      logic       load;
      logic [3:0] lv;
      logic       clr;
      logic [3:0] e_out;
      logic       e_tc;
      logic       e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic e, input logic u, input logic l,
                      input int lv, input logic c, input int eo, input logic et,
                      input logic ev);
      vec_t v;
      v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = 4'(lv); v.clr = c;
      v.e_out = 4'(eo); v.e_tc = et; v.e_ovf = ev;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive inputs, take one rising edge, then settle before sampling.
   task automatic apply(input logic r, input logic e, input logic u, input logic l,
                        input int lv, input logic c);
      rst = r; en = e; up = u; load = l; load_val = 4'(lv); clr_ovf = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p_en[8]  = '{1, 1, 1, 0, 0, 1, 1, 1};
      int p_out[8] = '{0, 0, 1, 1, 1, 1, 1, 2};

      // Main vectors for the MODULUS = 10, PRESCALE = 1 instance.
      add(0, 0, 1, 0, 0, 0,  0, 0, 0);
      for (int i = 1; i <= 10; i++)
         add(1, 1, 1, 0, 0, 0, i % 10, (i == 10), (i == 10));
      add(1, 0, 1, 0, 0, 0,  0, 0, 1);
      add(1, 1, 1, 1, 2, 0,  2, 0, 1);
      add(1, 1, 0, 0, 0, 0,  1, 0, 1);
      add(1, 1, 0, 0, 0, 0,  0, 0, 1);
      add(1, 1, 0, 0, 0, 0,  SAT ? 0 : 9, 1, 1);
      add(1, 0, 0, 0, 0, 1,  SAT ? 0 : 9, 0, 0);
      add(1, 1, 1, 1, 15, 0, 9, 0, 0);
      add(1, 1, 1, 0, 0, 1,  SAT ? 9 : 0, 1, 1);
      add(1, 0, 1, 0, 0, 1,  SAT ? 9 : 0, 0, 0);
      add(1, 0, 1, 1, 9, 0,  9, 0, 0);
      add(1, 1, 1, 1, 3, 0,  3, 0, 0);
      add(0, 1, 1, 1, 5, 0,  0, 0, 0);
      add(1, 1, 1, 0, 0, 0,  1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, int'(vecs[i].lv), vecs[i].clr);
         chk($sformatf("v%0d out", i), 32'(out10), 32'(vecs[i].e_out));
         chk($sformatf("v%0d tc", i),  32'(tc10),  32'(vecs[i].e_tc));
         chk($sformatf("v%0d ovf", i), 32'(ovf10), 32'(vecs[i].e_ovf));
      end

      // Prescaler: PRESCALE = 3, en dropped for two cycles after the first step.
      apply(0, 0, 1, 0, 0, 0);
      chk("presc reset out", 32'(out3), 32'd0);
      for (int i = 0; i < 8; i++) begin
         apply(1, 1'(p_en[i]), 1, 0, 0, 0);
         chk($sformatf("presc edge%0d out", i + 1), 32'(out3), 32'(p_out[i]));
      end
      // Direction change mid-prescale must not disturb the prescaler.
      apply(1, 1, 0, 0, 0, 0);
      chk("presc dir1 out", 32'(out3), 32'd2);
      apply(1, 1, 0, 0, 0, 0);
      chk("presc dir2 out", 32'(out3), 32'd2);
      apply(1, 1, 0, 0, 0, 0);
      chk("presc dir3 out", 32'(out3), 32'd1);
      // Load clears the prescaler: the next step needs three more enabled edges.
      apply(1, 1, 1, 0, 0, 0);
      apply(1, 1, 1, 1, 4, 0);
      chk("presc load out", 32'(out3), 32'd4);
      apply(1, 1, 1, 0, 0, 0);
      apply(1, 1, 1, 0, 0, 0);
      chk("presc after load 2 out", 32'(out3), 32'd4);
      apply(1, 1, 1, 0, 0, 0);
      chk("presc after load 3 out", 32'(out3), 32'd5);

      // Full range: MODULUS = 2^WIDTH wraps cleanly from 15.
      apply(1, 0, 1, 1, 15, 1);
      chk("full load out", 32'(out16), 32'd15);
      chk("full load ovf", 32'(ovf16), 32'd0);
      apply(1, 1, 1, 0, 0, 0);
      chk("full wrap out", 32'(out16), SAT ? 32'd15 : 32'd0);
      chk("full wrap tc", 32'(tc16), 32'd1);
      chk("full wrap ovf", 32'(ovf16), 32'd1);
      chk("full no x", 32'($isunknown(out16)), 32'd0);
      apply(1, 0, 1, 0, 0, 0);
      chk("full tc drop", 32'(tc16), 32'd0);
      chk("full ovf sticky", 32'(ovf16), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
